// File: rtl/axis_vid_out_sc.sv
// AXI4-Stream video to native video bridge: FWFT FIFO, SOF alignment to the VTG, registered video outputs.
// Optional underflow counter built when AXIS_VID_OUT_ERR_CNT_EN is defined.
module axis_vid_out_sc #(
  parameter int DATA_WIDTH       = 16,
  parameter int PPC              = 1,
  parameter int ADDR_BITS        = 10,
  parameter int HYSTERESIS_LEVEL = 12
) (
  input  logic                          aclk,
  input  logic                          rst,
  input  logic                          aclken,
  input  logic [DATA_WIDTH*PPC-1:0]     s_axis_video_tdata,
  input  logic                          s_axis_video_tvalid,
  output logic                          s_axis_video_tready,
  input  logic                          s_axis_video_tuser,
  input  logic                          s_axis_video_tlast,
  input  logic                          vtg_vsync,
  input  logic                          vtg_hsync,
  input  logic                          vtg_vblank,
  input  logic                          vtg_hblank,
  input  logic                          vtg_act_vid,
  output logic                          vtg_ce,
  output logic                          video_de,
  output logic                          video_vsync,
  output logic                          video_hsync,
  output logic                          video_vblank,
  output logic                          video_hblank,
  output logic [DATA_WIDTH*PPC-1:0]     video_data,
  output logic                          locked,
  output logic                          underflow,
  output logic [ADDR_BITS:0]            fifo_level,
  output logic                          empty,
  output logic [15:0]                   underflow_count
);

  localparam int W     = DATA_WIDTH * PPC;
  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS:0] FULL_LVL = (ADDR_BITS + 1)'(DEPTH);
  localparam logic [ADDR_BITS:0] HYST_LVL = (ADDR_BITS + 1)'(HYSTERESIS_LEVEL);

  typedef enum logic [1:0] {IDLE, ALIGN, LOCKED} state_t;

  state_t state, state_nxt;

  logic [W+1:0]         mem [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr, rd_ptr;
  logic [ADDR_BITS:0]   level;
  logic                 full, fifo_empty, wr_en, rd_en;
  logic                 head_sof;
  logic [W-1:0]         head_data;

  logic sof_armed, ce_released;
  logic pop, lock_now, underflow_evt, out_pixel, vtg_ce_c;

  assign full                = (level == FULL_LVL);
  assign fifo_empty          = (level == '0);
  assign s_axis_video_tready = aclken & ~full;
  assign wr_en               = s_axis_video_tvalid & s_axis_video_tready;
  assign rd_en               = pop & aclken & ~fifo_empty;
  assign head_sof            = mem[rd_ptr][W+1];
  assign head_data           = mem[rd_ptr][W-1:0];

  // NOTE: the storage array carries no reset; only pointers and level define its contents.
  always_ff @(posedge aclk) begin
    if (wr_en) mem[wr_ptr] <= {s_axis_video_tuser, s_axis_video_tlast, s_axis_video_tdata};
  end

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge aclk or posedge rst) begin
    if (rst)         state <= IDLE;
    else if (aclken) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!fifo_empty && head_sof) state_nxt = ALIGN;
      ALIGN:   if (lock_now) state_nxt = LOCKED;
      LOCKED:  if (vtg_act_vid && (fifo_empty || (head_sof && !sof_armed))) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    vtg_ce_c      = 1'b0;
    pop           = 1'b0;
    lock_now      = 1'b0;
    underflow_evt = 1'b0;
    out_pixel     = 1'b0;
    case (state)
      IDLE: pop = !fifo_empty && !head_sof;
      ALIGN: begin
        vtg_ce_c  = ce_released || (level >= HYST_LVL);
        lock_now  = sof_armed && vtg_act_vid && vtg_ce_c && !fifo_empty;
        pop       = lock_now;
        out_pixel = lock_now;
      end
      LOCKED: begin
        vtg_ce_c = 1'b1;
        if (vtg_act_vid) begin
          if (fifo_empty) begin
            underflow_evt = 1'b1;
          end else if (!head_sof || sof_armed) begin
            pop       = 1'b1;
            out_pixel = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Vsync arms the SOF expectation; the first active pixel consumes it.
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      sof_armed   <= 1'b0;
      ce_released <= 1'b0;
    end else if (aclken) begin
      ce_released <= (state == ALIGN) && (state_nxt == ALIGN) && vtg_ce_c;
      case (state)
        ALIGN:   sof_armed <= lock_now ? 1'b0 : (sof_armed | vtg_vsync);
        LOCKED: begin
          if (state_nxt != LOCKED) sof_armed <= 1'b0;
          else if (vtg_vsync)      sof_armed <= 1'b1;
          else if (pop)            sof_armed <= 1'b0;
        end
        default: sof_armed <= 1'b0;
      endcase
    end
  end

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      video_de     <= 1'b0;
      video_data   <= '0;
      video_vsync  <= 1'b0;
      video_hsync  <= 1'b0;
      video_vblank <= 1'b0;
      video_hblank <= 1'b0;
      underflow    <= 1'b0;
    end else if (aclken) begin
      video_de     <= out_pixel;
      video_data   <= out_pixel ? head_data : '0;
      video_vsync  <= vtg_ce_c & vtg_vsync;
      video_hsync  <= vtg_ce_c & vtg_hsync;
      video_vblank <= vtg_ce_c & vtg_vblank;
      video_hblank <= vtg_ce_c & vtg_hblank;
      underflow    <= underflow_evt;
    end
  end

`ifdef AXIS_VID_OUT_ERR_CNT_EN
  always_ff @(posedge aclk or posedge rst) begin
    if (rst)
      underflow_count <= '0;
    else if (aclken && underflow_evt && (underflow_count != 16'hFFFF))
      underflow_count <= underflow_count + 16'd1;
  end
`else
  assign underflow_count = '0;
`endif

  assign vtg_ce     = vtg_ce_c;
  assign locked     = (state == LOCKED);
  assign fifo_level = level;
  assign empty      = fifo_empty;

endmodule

// File: tb/tb_axis_vid_out_sc.sv
// Directed bench for axis_vid_out_sc: reset, flush/align, one 64x4 frame, clock-enable freeze,
// underflow, full FIFO with simultaneous pop, and reset mid-stream.
module tb_axis_vid_out_sc;

  localparam int DW = 16;
  localparam int PPC = 1;
  localparam int AB = 10;
  localparam int HL = 12;
  localparam int W = DW * PPC;

  logic          aclk = 1'b0;
  logic          rst, aclken;
  logic [W-1:0]  tdata;
  logic          tvalid, tready, tuser, tlast;
  logic          vtg_vsync, vtg_hsync, vtg_vblank, vtg_hblank, vtg_act_vid, vtg_ce;
  logic          video_de, video_vsync, video_hsync, video_vblank, video_hblank;
  logic [W-1:0]  video_data;
  logic          locked, underflow, empty;
  logic [AB:0]   fifo_level;
  logic [15:0]   underflow_count;

  int checks = 0;
  int errors = 0;

  axis_vid_out_sc #(
    .DATA_WIDTH(DW), .PPC(PPC), .ADDR_BITS(AB), .HYSTERESIS_LEVEL(HL)
  ) dut (
    .aclk(aclk), .rst(rst), .aclken(aclken),
    .s_axis_video_tdata(tdata), .s_axis_video_tvalid(tvalid),
    .s_axis_video_tready(tready), .s_axis_video_tuser(tuser),
    .s_axis_video_tlast(tlast),
    .vtg_vsync(vtg_vsync), .vtg_hsync(vtg_hsync), .vtg_vblank(vtg_vblank),
    .vtg_hblank(vtg_hblank), .vtg_act_vid(vtg_act_vid), .vtg_ce(vtg_ce),
    .video_de(video_de), .video_vsync(video_vsync), .video_hsync(video_hsync),
    .video_vblank(video_vblank), .video_hblank(video_hblank),
    .video_data(video_data), .locked(locked), .underflow(underflow),
    .fifo_level(fifo_level), .empty(empty), .underflow_count(underflow_count)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] d, input logic u);
    tvalid = 1'b1;
    tdata  = d;
    tuser  = u;
    cyc();
    tvalid = 1'b0;
    tuser  = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_tready"},  tready, 1);
    check({tag, "_level"},   fifo_level, 0);
    check({tag, "_empty"},   empty, 1);
    check({tag, "_locked"},  locked, 0);
    check({tag, "_de"},      video_de, 0);
    check({tag, "_data"},    video_data, 0);
    check({tag, "_vsync"},   video_vsync, 0);
    check({tag, "_hblank"},  video_hblank, 0);
    check({tag, "_uflow"},   underflow, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] exp_px;
    int p;

    rst = 1'b1; aclken = 1'b1; tdata = '0; tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0;
    vtg_vsync = 1'b0; vtg_hsync = 1'b0; vtg_vblank = 1'b0; vtg_hblank = 1'b0; vtg_act_vid = 1'b0;
    repeat (3) cyc();
    check_quiet("reset");
    check("reset_vtg_ce", vtg_ce, 0);
    check("reset_ucnt", underflow_count, 0);
    rst = 1'b0;
    cyc();

    // Sync outputs are gated while the VTG is disabled in IDLE.
    vtg_vsync = 1'b1; vtg_vblank = 1'b1;
    cyc();
    check("idle_vsync_gated", video_vsync, 0);
    check("idle_vblank_gated", video_vblank, 0);
    vtg_vsync = 1'b0; vtg_vblank = 1'b0;

    // Three non-SOF beats are flushed; the SOF beat stays at the head.
    push(16'h0001, 1'b0);
    push(16'h0002, 1'b0);
    push(16'h0003, 1'b0);
    push(16'hA5A5, 1'b1);
    check("flush_level", fifo_level, 1);
    cyc();
    cyc();
    check("align_level", fifo_level, 1);
    check("align_ce_low", vtg_ce, 0);
    check("align_unlocked", locked, 0);

    for (int i = 1; i <= 10; i++) push(16'h1000 + 16'(i), 1'b0);
    check("hyst_level_11", fifo_level, 11);
    check("hyst_ce_11", vtg_ce, 0);
    push(16'h100B, 1'b0);
    check("hyst_level_12", fifo_level, 12);
    check("hyst_ce_12", vtg_ce, 1);
    for (int i = 12; i <= 255; i++) push(16'h1000 + 16'(i), 1'b0);
    check("frame_buffered", fifo_level, 256);

    vtg_vsync = 1'b1; vtg_vblank = 1'b1;
    cyc();
    check("align_vsync_out", video_vsync, 1);
    check("align_still_unlocked", locked, 0);
    vtg_vsync = 1'b0;
    repeat (3) cyc();
    vtg_vblank = 1'b0;

    p = 0;
    for (int line = 0; line < 4; line++) begin
      for (int x = 0; x < 64; x++) begin
        vtg_act_vid = 1'b1;
        cyc();
        exp_px = (p == 0) ? 16'hA5A5 : 16'h1000 + 16'(p);
        check("frame_de", video_de, 1);
        check("frame_data", video_data, exp_px);
        check("frame_locked", locked, 1);
        check("frame_uflow", underflow, 0);
        p++;
      end
      vtg_act_vid = 1'b0; vtg_hblank = 1'b1;
      for (int g = 0; g < 8; g++) begin
        cyc();
        check("gap_hblank", video_hblank, 1);
        if (g == 0) begin
          check("gap_de", video_de, 0);
          check("gap_data", video_data, 0);
        end
      end
      vtg_hblank = 1'b0;
    end
    check("frame_drained", fifo_level, 0);
    check("frame_locked_end", locked, 1);

    // Clock-enable freeze in the middle of a line.
    for (int i = 0; i < 20; i++) push(16'h2000 + 16'(i), 1'b0);
    check("pre_freeze_level", fifo_level, 20);
    for (int i = 0; i < 4; i++) begin
      vtg_act_vid = 1'b1;
      cyc();
      check("pre_freeze_data", video_data, 16'h2000 + 16'(i));
    end
    aclken = 1'b0; tvalid = 1'b1; tdata = 16'hDEAD; vtg_hblank = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("freeze_level", fifo_level, 16);
      check("freeze_de", video_de, 1);
      check("freeze_data", video_data, 16'h2003);
      check("freeze_tready", tready, 0);
      check("freeze_hblank", video_hblank, 0);
      check("freeze_locked", locked, 1);
    end
    aclken = 1'b1; tvalid = 1'b0; vtg_hblank = 1'b0;
    for (int i = 4; i < 20; i++) begin
      cyc();
      check("resume_de", video_de, 1);
      check("resume_data", video_data, 16'h2000 + 16'(i));
    end

    // Stream starves mid-line: one-cycle underflow, drop to IDLE.
    cyc();
    check("uflow_pulse", underflow, 1);
    check("uflow_unlocked", locked, 0);
    check("uflow_de", video_de, 0);
    check("uflow_data", video_data, 0);
`ifdef AXIS_VID_OUT_ERR_CNT_EN
    check("uflow_count", underflow_count, 1);
`else
    check("uflow_count", underflow_count, 0);
`endif
    vtg_act_vid = 1'b0;
    cyc();
    check("uflow_one_cycle", underflow, 0);

    // Fill to full depth behind a held SOF, then pop with tvalid held high.
    push(16'hBEEF, 1'b1);
    for (int i = 1; i < 1024; i++) push(16'h4000 + 16'(i), 1'b0);
    check("full_level", fifo_level, 1024);
    check("full_tready", tready, 0);
    vtg_vsync = 1'b1;
    cyc();
    vtg_vsync = 1'b0;
    cyc();
    tvalid = 1'b1; tdata = 16'h5555; tuser = 1'b0; vtg_act_vid = 1'b1;
    check("full_tready_pre_pop", tready, 0);
    cyc();
    check("pop_level", fifo_level, 1023);
    check("pop_tready", tready, 1);
    check("pop_locked", locked, 1);
    check("pop_data", video_data, 16'hBEEF);
    cyc();
    check("rw_level", fifo_level, 1023);
    check("rw_data", video_data, 16'h4001);

    // Reset mid-stream.
    #2;
    rst = 1'b1;
    cyc();
    check_quiet("midrst");
    check("midrst_ucnt", underflow_count, 0);
    rst = 1'b0; tvalid = 1'b0; vtg_act_vid = 1'b0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
